// File: rtl/pipe_pkg.sv
// Shared types and helpers for the parametrised pipeline register chain.
//   sel_w()     : stage-index width, clog2 with a floor of 1
//   REG_ZERO    : architectural zero register, never forwarded
//   pipe_entry_t: default-width stage entry {valid, regwrite, rd, data}
package pipe_pkg;

  localparam int unsigned REG_ZERO    = 0;
  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_RD_W   = 5;

  // Default-width entry matching the classic 5-stage core's bank layout.
  typedef struct packed {
    logic                   valid;
    logic                   regwrite;
    logic [PIPE_RD_W-1:0]   rd;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

  // Stage-index width; a single stage still needs one select bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Bus bundle for pipe_stage_chain: input handshake, stall/flush control,
// chain outputs and the forwarding lookup ports.
//   master: producer/controller side (drives in_*, masks, src_rs)
//   slave : the chain itself
interface pipe_stage_chain_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned N_SRC  = 2
);
  localparam int unsigned SEL_W = pipe_pkg::sel_w(STAGES);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [RD_W-1:0]         in_rd;
  logic                    in_regwrite;
  logic [STAGES-1:0]       stall_mask;
  logic [STAGES-1:0]       flush_mask;
  logic [STAGES-1:0]       stg_valid;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [RD_W-1:0]         out_rd;
  logic                    out_regwrite;
  logic [N_SRC*RD_W-1:0]   src_rs;
  logic [N_SRC-1:0]        fwd_hit;
  logic [N_SRC*SEL_W-1:0]  fwd_stage;
  logic [N_SRC*DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_data, in_rd, in_regwrite, stall_mask, flush_mask, src_rs,
    input  in_ready, stg_valid, out_valid, out_data, out_rd, out_regwrite,
           fwd_hit, fwd_stage, fwd_data
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_regwrite, stall_mask, flush_mask, src_rs,
    output in_ready, stg_valid, out_valid, out_data, out_rd, out_regwrite,
           fwd_hit, fwd_stage, fwd_data
  );

endinterface

// File: rtl/pipe_fwd_match.sv
// Single forwarding lookup: priority search over all stages, youngest
// (lowest index) valid regwrite entry whose rd matches rs wins.
//   stg_valid/stg_regwrite : per-stage flags
//   stg_rd/stg_data       : per-stage fields, stage i at slice i
//   rs                    : register being looked up (zero never hits)
//   hit/stage/data_o      : result; data_o is 0 when there is no hit
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [STAGES-1:0]        stg_valid,
  input  logic [STAGES-1:0]        stg_regwrite,
  input  logic [STAGES*RD_W-1:0]   stg_rd,
  input  logic [STAGES*DATA_W-1:0] stg_data,
  input  logic [RD_W-1:0]          rs,
  output logic                     hit,
  output logic [SEL_W-1:0]         stage,
  output logic [DATA_W-1:0]        data_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit    = 1'b0;
    stage  = '0;
    data_o = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (stg_valid[i] && stg_regwrite[i] &&
          (stg_rd[i*RD_W +: RD_W] == rs) && (rs != RD_W'(REG_ZERO))) begin
        hit    = 1'b1;
        stage  = SEL_W'(i);
        data_o = stg_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of STAGES inter-stage registers (stage 0 youngest) with
// per-stage stall/flush masks, an input handshake and N_SRC forwarding ports.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : pipe_stage_chain_if.slave (handshake, masks, outputs, lookups)
// Optional PIPE_STAGE_CHAIN_PERF_EN adds perf_stall_cyc, perf_flush_cnt and
// perf_retired 32-bit wrapping counters.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned N_SRC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_stage_chain_if.slave       bus
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  ,
  output logic [31:0]             perf_stall_cyc,
  output logic [31:0]             perf_flush_cnt,
  output logic [31:0]             perf_retired
`endif
);

  localparam int unsigned SEL_W = sel_w(STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t stg_q [STAGES];
  entry_t stg_n [STAGES];  // next contents before flush
  entry_t stg_d [STAGES];  // next contents after flush

  logic [STAGES-1:0]        hold;
  logic [STAGES-1:0]        v_vec;
  logic [STAGES-1:0]        rw_vec;
  logic [STAGES*RD_W-1:0]   rd_flat;
  logic [STAGES*DATA_W-1:0] data_flat;

  logic              hit_k   [N_SRC];
  logic [SEL_W-1:0]  stage_k [N_SRC];
  logic [DATA_W-1:0] data_k  [N_SRC];

  // A stall on stage j freezes j and everything upstream of it.
  always_comb begin
    hold = '0;
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = |(bus.stall_mask >> i);
    end
    bus.in_ready = ~hold[0];
  end

  // Next-state: hold, bubble behind a frozen stage, or shift; flush last.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stg_n[i] = stg_q[i];
    end
    if (!hold[0]) begin
      stg_n[0].valid    = bus.in_valid;
      stg_n[0].regwrite = bus.in_regwrite;
      stg_n[0].rd       = bus.in_rd;
      stg_n[0].data     = bus.in_data;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (!hold[i]) begin
        if (hold[i-1]) begin
          stg_n[i].valid = 1'b0;
        end else begin
          stg_n[i] = stg_q[i-1];
        end
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      stg_d[i]       = stg_n[i];
      stg_d[i].valid = stg_n[i].valid & ~bus.flush_mask[i];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  // Flattened stage view for outputs and lookups.
  always_comb begin
    v_vec     = '0;
    rw_vec    = '0;
    rd_flat   = '0;
    data_flat = '0;
    for (int i = 0; i < STAGES; i++) begin
      v_vec[i]                       = stg_q[i].valid;
      rw_vec[i]                      = stg_q[i].regwrite;
      rd_flat[i*RD_W +: RD_W]        = stg_q[i].rd;
      data_flat[i*DATA_W +: DATA_W]  = stg_q[i].data;
    end
    bus.stg_valid    = v_vec;
    bus.out_valid    = stg_q[LAST].valid;
    bus.out_data     = stg_q[LAST].data;
    bus.out_rd       = stg_q[LAST].rd;
    bus.out_regwrite = stg_q[LAST].valid & stg_q[LAST].regwrite;
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_fwd
    pipe_fwd_match #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_match (
      .stg_valid    (v_vec),
      .stg_regwrite (rw_vec),
      .stg_rd       (rd_flat),
      .stg_data     (data_flat),
      .rs           (bus.src_rs[k*RD_W +: RD_W]),
      .hit          (hit_k[k]),
      .stage        (stage_k[k]),
      .data_o       (data_k[k])
    );
  end

  // Pack per-port lookup results onto the bus.
  always_comb begin
    bus.fwd_hit   = '0;
    bus.fwd_stage = '0;
    bus.fwd_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      bus.fwd_hit[k]                     = hit_k[k];
      bus.fwd_stage[k*SEL_W +: SEL_W]    = stage_k[k];
      bus.fwd_data[k*DATA_W +: DATA_W]   = data_k[k];
    end
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] kill_cnt;

  // Valid entries that would have landed in a flushed stage this edge.
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      kill_cnt = kill_cnt + 32'(stg_n[i].valid & bus.flush_mask[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_retired   <= '0;
    end else begin
      if (|bus.stall_mask) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      perf_flush_cnt <= perf_flush_cnt + kill_cnt;
      if (stg_q[LAST].valid && !bus.stall_mask[LAST]) begin
        perf_retired <= perf_retired + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the hand-wired IF/ID, ID/EX, EX/MEM, MEM/WB register banks of the 5-stage MIPS core.
- One chain of STAGES inter-stage registers, each carrying a valid bit, a DATA_W payload, a destination-register index and a RegWrite flag.
- Per-stage stall and flush masks, input handshake, and N_SRC forwarding lookups that return the youngest matching in-flight result.
- Replaces the ad-hoc stall (PCWrite/IFIDWrite) and forwarding muxes spread across I_DECODE and EXECUTE.

Parameters:
- DATA_W, 32, payload width (result value).
- RD_W, 5, destination-register index width.
- STAGES, 3, number of chained registers (>=1); stage 0 is youngest.
- N_SRC, 2, number of forwarding lookup ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  new entry offered to stage 0.
- in_ready  out  1  stage 0 accepts this cycle.
- in_data  in  DATA_W  payload.
- in_rd  in  RD_W  destination register.
- in_regwrite  in  1  entry writes the register file.
- stall_mask  in  STAGES  bit i: hold stage i this edge.
- flush_mask  in  STAGES  bit i: invalidate the value written into stage i this edge.
- stg_valid  out  STAGES  valid bit of each stage.
- out_valid  out  1  = stg_valid[STAGES-1].
- out_data  out  DATA_W  payload of last stage.
- out_rd  out  RD_W  rd of last stage.
- out_regwrite  out  1  regwrite of last stage, gated by out_valid.
- src_rs  in  N_SRC*RD_W  lookup register indices.
- fwd_hit  out  N_SRC  match found.
- fwd_stage  out  N_SRC*SEL_W  matching stage index; SEL_W = max(1, clog2(STAGES)).
- fwd_data  out  N_SRC*DATA_W  matching payload; 0 when no hit.

Behaviour:
- Reset (rst=0, asynchronous): all valid=0, data=0, rd=0, regwrite=0. Hence out_valid=0, out_data=0, out_rd=0, out_regwrite=0, fwd_hit=0, fwd_stage=0, fwd_data=0. in_ready is combinational and reads 1 during reset when stall_mask=0.
- hold[i] = OR(stall_mask[j]) for j>=i. A stall freezes that stage and every upstream stage.
- Per edge, for each stage i:
  - hold[i]=1: the stage keeps its contents.
  - i>0, hold[i-1]=1, hold[i]=0: the stage loads a bubble (valid=0).
  - Otherwise it loads stage i-1, or for i=0 the input: valid=in_valid, plus data/rd/regwrite.
- Flush: flush_mask[i]=1 forces the stage's next valid=0, overriding hold and load. Data/rd may keep stale values but are ignored.
- Handshake: in_ready = ~hold[0]. The input is accepted iff in_valid & in_ready. When in_ready=0, the source holds its inputs.
- Latency: an accepted entry appears at the output STAGES edges later when there are no stalls. Each stall cycle on a stage at or downstream of the entry adds one cycle.
- Last stage: the consumer is always ready. The entry leaves on the next edge unless stall_mask[STAGES-1]=1.
- Forwarding (combinational from registers), for each port k:
  - Candidate stage i: valid[i] & regwrite[i] & rd[i]==src_rs[k] & src_rs[k]!=0.
  - The lowest index (youngest) candidate wins. fwd_stage is that index; fwd_data is its payload.
  - A stage being flushed or held this cycle still forwards its current contents.
- Register 0 never hits, whatever the entry's regwrite.
- Mid-operation reset clears all state immediately. No partial entry survives.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- When defined, adds three 32-bit outputs:
  - perf_stall_cyc: counts cycles with any stall_mask bit set.
  - perf_flush_cnt: counts valid entries destroyed by flush.
  - perf_retired: counts cycles with out_valid=1 and stall_mask[STAGES-1]=0.
- Counters wrap at 2^32 and reset to 0 on rst.
- When not defined, the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg: SEL_W function (clog2 with floor 1), REG_ZERO constant (0), and an entry struct/typedef {valid, regwrite, rd, data}.
- One sub-module, pipe_fwd_match: a single forwarding lookup (priority search over stages), instantiated N_SRC times.

Test Plan:
- Reset, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles (STAGES=3) -> out_data 0x11, 0x22, 0x33 appear on edges 3, 4, 5; out_valid=1 for exactly 3 cycles.
- Chain full of 0xA/0xB/0xC, stall_mask=3'b010 for 2 cycles -> in_ready=0, stages 0 and 1 frozen; stage 2 emits 0xC then a bubble; the stream resumes with no loss or duplication.
- flush_mask=3'b011 while stage 0 holds rd=4 and stage 1 holds rd=5 -> both stages are invalid after the edge; out_valid later shows two bubbles; perf_flush_cnt=2 when the macro is enabled.
- Stage 0 = {rd=7, 0x70, regwrite=1}, stage 2 = {rd=7, 0x72, regwrite=1}, src_rs[0]=7 -> fwd_hit[0]=1, fwd_stage[0]=0, fwd_data[0]=0x70. Clearing stage 0's regwrite -> fwd_stage[0]=2, fwd_data[0]=0x72.
- src_rs[1]=0 while a valid regwrite entry with rd=0 is present -> fwd_hit[1]=0, fwd_data[1]=0.
- Assert rst=0 asynchronously mid-stream with out_valid=1 -> outputs clear before the next clock edge; the first entry after release reaches the output after exactly STAGES edges.
